// File: rtl/branch_predictor_btb.sv
// Branch target buffer with 2-bit saturating direction counters.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   lookup_pc            - fetch PC; pred_hit/pred_taken/pred_next_pc are
//                          combinational from the current table contents
//   upd_valid/upd_pc/upd_taken/upd_target/upd_mispredict
//                        - resolved branch/jump writeback from decode
//   invalidate_all       - clear every valid bit (fence.i / context change)
//   stat_branches        - saturating count of resolved updates
//   stat_mispredicts     - saturating count of mispredicted updates
module branch_predictor_btb #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  lookup_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_next_pc,
  input  logic             upd_valid,
  input  logic [XLEN-1:0]  upd_pc,
  input  logic             upd_taken,
  input  logic [XLEN-1:0]  upd_target,
  input  logic             upd_mispredict,
  input  logic             invalidate_all,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [XLEN-1:0]    target_d [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];
  logic [CNT_W-1:0]   br_q, br_d, mp_q, mp_d;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_hit;

  // Byte-offset bits of the update PC do not participate in mapping.
  logic unused_upd_pc_lsb;
  assign unused_upd_pc_lsb = ^upd_pc[1:0];

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[XLEN-1:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[XLEN-1:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // Zero-latency lookup from the registered table (no write bypass).
  always_comb begin
    pred_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken   = pred_hit && ctr_q[lk_idx][1];
    pred_next_pc = pred_taken ? target_q[lk_idx] : lookup_pc + XLEN'(4);
  end

  // Next-state table: invalidate_all wins over the table update.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (invalidate_all) begin
      valid_d = '0;
    end else if (upd_valid) begin
      if (up_hit) begin
        if (upd_taken) begin
          if (ctr_q[up_idx] != 2'b11) ctr_d[up_idx] = ctr_q[up_idx] + 2'b01;
          target_d[up_idx] = upd_target;
        end else begin
          if (ctr_q[up_idx] != 2'b00) ctr_d[up_idx] = ctr_q[up_idx] - 2'b01;
        end
      end else if (upd_taken) begin
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = upd_target;
        ctr_d[up_idx]    = 2'b10;
      end
    end
  end

  // Saturating statistics; counted regardless of invalidate_all.
  always_comb begin
    br_d = br_q;
    mp_d = mp_q;
    if (upd_valid) begin
      if (br_q != '1) br_d = br_q + CNT_W'(1);
      if (upd_mispredict && (mp_q != '1)) mp_d = mp_q + CNT_W'(1);
    end
  end

  // Valid bits, counters and statistics are reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) ctr_q[i] <= 2'b01;
      br_q <= '0;
      mp_q <= '0;
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
      br_q    <= br_d;
      mp_q    <= mp_d;
    end
  end

  // Tag and target storage needs no reset; a reset cycle freezes it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tag_q    <= tag_d;
      target_q <= target_d;
    end
  end

  assign stat_branches    = br_q;
  assign stat_mispredicts = mp_q;

endmodule
